// File: rtl/bsg_gray_pkg.sv
// rtl/bsg_gray_pkg.sv - gray/binary conversion helpers and side selector
package bsg_gray_pkg;

  typedef enum logic {
    WRITE_SIDE = 1'b0,
    READ_SIDE  = 1'b1
  } side_e;

  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the xor of all gray bits at or above it; zero-extension keeps this width-agnostic.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/bsg_async_ptr_gray_side_if.sv
// rtl/bsg_async_ptr_gray_side_if.sv - pointer-side handshake and status bundle
interface bsg_async_ptr_gray_side_if #(parameter int pw_p = 6);
  logic            inc;
  logic [pw_p-1:0] remote_ptr_gray;
  logic [pw_p-1:0] ptr_binary_r;
  logic [pw_p-1:0] ptr_gray_r;
  logic [pw_p-1:0] remote_ptr_binary;
  logic [pw_p-1:0] count;
  logic            stop;
  logic            overflow_r;

  modport master (
    output inc, remote_ptr_gray,
    input  ptr_binary_r, ptr_gray_r, remote_ptr_binary, count, stop, overflow_r
  );

  modport slave (
    input  inc, remote_ptr_gray,
    output ptr_binary_r, ptr_gray_r, remote_ptr_binary, count, stop, overflow_r
  );
endinterface

// File: rtl/bsg_async_ptr_gray_side_core.sv
// rtl/bsg_async_ptr_gray_side_core.sv - local pointer, remote sync and full/empty logic
module bsg_async_ptr_gray_side_core
  import bsg_gray_pkg::*;
#(
  parameter int lg_size_p     = 5,
  parameter int sync_stages_p = 2,
  parameter int read_side_p   = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bsg_async_ptr_gray_side_if.slave    bus
);

  localparam int               pw_lp    = lg_size_p + 1;
  localparam logic [pw_lp-1:0] depth_lp = pw_lp'(1 << lg_size_p);
  localparam side_e            side_lp  = (read_side_p != 0) ? READ_SIDE : WRITE_SIDE;

  logic [pw_lp-1:0] ptr_bin_q, ptr_bin_d;
  logic [pw_lp-1:0] ptr_gray_q, ptr_gray_d;
  logic             overflow_q, overflow_d;
  logic [pw_lp-1:0] remote_gray_sync;
  logic [pw_lp-1:0] remote_bin;
  logic [pw_lp-1:0] used;
  logic [pw_lp-1:0] count;
  logic             stop;
  logic             accept;

  bsg_gray_sync_chain #(
    .width_p  (pw_lp),
    .stages_p (sync_stages_p)
  ) u_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (bus.remote_ptr_gray),
    .q_o       (remote_gray_sync)
  );

  assign remote_bin = pw_lp'(gray_to_bin(32'(remote_gray_sync)));

  // Status is built only from flops so a lagging remote pointer can only make it more pessimistic.
  always_comb begin
    used  = ptr_bin_q - remote_bin;
    count = '0;
    stop  = 1'b0;
    if (side_lp == READ_SIDE) begin
      count = remote_bin - ptr_bin_q;
      stop  = (count == '0);
    end else begin
      count = depth_lp - used;
      stop  = (used == depth_lp);
    end
  end

  always_comb begin
    accept     = bus.inc & ~stop;
    ptr_bin_d  = ptr_bin_q;
    ptr_gray_d = ptr_gray_q;
    overflow_d = overflow_q | (bus.inc & stop);
    if (accept) begin
      ptr_bin_d  = ptr_bin_q + 1'b1;
      ptr_gray_d = pw_lp'(bin_to_gray(32'(ptr_bin_d)));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.ptr_binary_r      = ptr_bin_q;
  assign bus.ptr_gray_r        = ptr_gray_q;
  assign bus.remote_ptr_binary = remote_bin;
  assign bus.count             = count;
  assign bus.stop              = stop;
  assign bus.overflow_r        = overflow_q;

endmodule

// File: rtl/bsg_gray_sync_chain.sv
// rtl/bsg_gray_sync_chain.sv - multi-flop synchronizer for a gray-coded bus
module bsg_gray_sync_chain #(
  parameter int width_p  = 6,
  parameter int stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] stage_q [stages_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < stages_p; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < stages_p; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[stages_p-1];

endmodule

// File: rtl/bsg_async_ptr_gray_side.sv
// rtl/bsg_async_ptr_gray_side.sv - one side of an async FIFO pointer pair
module bsg_async_ptr_gray_side #(
  parameter int lg_size_p     = 5,
  parameter int sync_stages_p = 2,
  parameter int read_side_p   = 0,
  localparam int pw = lg_size_p + 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          inc_i,
  input  logic [pw-1:0] remote_ptr_gray_i,
  output logic [pw-1:0] ptr_binary_r_o,
  output logic [pw-1:0] ptr_gray_r_o,
  output logic [pw-1:0] remote_ptr_binary_o,
  output logic [pw-1:0] count_o,
  output logic          stop_o,
  output logic          overflow_r_o
);

  bsg_async_ptr_gray_side_if #(.pw_p(pw)) bus ();

  assign bus.inc             = inc_i;
  assign bus.remote_ptr_gray = remote_ptr_gray_i;

  bsg_async_ptr_gray_side_core #(
    .lg_size_p     (lg_size_p),
    .sync_stages_p (sync_stages_p),
    .read_side_p   (read_side_p)
  ) u_core (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus.slave)
  );

  assign ptr_binary_r_o      = bus.ptr_binary_r;
  assign ptr_gray_r_o        = bus.ptr_gray_r;
  assign remote_ptr_binary_o = bus.remote_ptr_binary;
  assign count_o             = bus.count;
  assign stop_o              = bus.stop;
  assign overflow_r_o        = bus.overflow_r;

endmodule

// File: tb/tb_bsg_async_ptr_gray_side.sv
// tb/tb_bsg_async_ptr_gray_side.sv - scoreboard bench for write and read pointer sides
module tb_bsg_async_ptr_gray_side;

  typedef struct {
    string      name;
    bit         side;
    logic [2:0] pb;
    logic [2:0] pg;
    logic [2:0] rb;
    logic [2:0] cnt;
    logic       stop;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic run = 1'b1;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  event chk_ev;

  logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  bsg_async_ptr_gray_side_if #(.pw_p(3)) wi ();
  bsg_async_ptr_gray_side_if #(.pw_p(3)) ri ();

  bsg_async_ptr_gray_side #(.lg_size_p(2), .sync_stages_p(2), .read_side_p(0)) dut_w (
    .clk_i               (clk),
    .reset_n_i           (rst_n),
    .inc_i               (wi.inc),
    .remote_ptr_gray_i   (wi.remote_ptr_gray),
    .ptr_binary_r_o      (wi.ptr_binary_r),
    .ptr_gray_r_o        (wi.ptr_gray_r),
    .remote_ptr_binary_o (wi.remote_ptr_binary),
    .count_o             (wi.count),
    .stop_o              (wi.stop),
    .overflow_r_o        (wi.overflow_r)
  );

  bsg_async_ptr_gray_side #(.lg_size_p(2), .sync_stages_p(2), .read_side_p(1)) dut_r (
    .clk_i               (clk),
    .reset_n_i           (rst_n),
    .inc_i               (ri.inc),
    .remote_ptr_gray_i   (ri.remote_ptr_gray),
    .ptr_binary_r_o      (ri.ptr_binary_r),
    .ptr_gray_r_o        (ri.ptr_gray_r),
    .remote_ptr_binary_o (ri.remote_ptr_binary),
    .count_o             (ri.count),
    .stop_o              (ri.stop),
    .overflow_r_o        (ri.overflow_r)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic expect_state(input string name, input bit side, input logic [2:0] pb,
                              input logic [2:0] pg, input logic [2:0] rb, input logic [2:0] cnt,
                              input logic stop, input logic ovf);
    exp_t e;
    e.name = name; e.side = side; e.pb = pb; e.pg = pg;
    e.rb = rb; e.cnt = cnt; e.stop = stop; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation against the side it names.
  initial begin
    exp_t       e;
    logic [13:0] act, want;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.side)
          act = {ri.ptr_binary_r, ri.ptr_gray_r, ri.remote_ptr_binary, ri.count, ri.stop, ri.overflow_r};
        else
          act = {wi.ptr_binary_r, wi.ptr_gray_r, wi.remote_ptr_binary, wi.count, wi.stop, wi.overflow_r};
        want = {e.pb, e.pg, e.rb, e.cnt, e.stop, e.ovf};
        total++;
        if (act !== want) begin
          bad++;
          $display("FAIL %s pb/pg/rb/cnt/stop/ovf actual=%b required=%b", e.name, act, want);
        end
      end
    end
  end

  initial begin
    wi.inc = 1'b0; wi.remote_ptr_gray = 3'b000;
    ri.inc = 1'b0; ri.remote_ptr_gray = 3'b000;
    #2;
    expect_state("w_reset", 0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0);
    expect_state("r_reset", 1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    wi.inc = 1'b1; ri.remote_ptr_gray = 3'b001;
    tick();
    ri.remote_ptr_gray = 3'b011;
    tick();
    expect_state("w_inc2", 0, 3'b010, 3'b011, 3'b000, 3'b010, 1'b0, 1'b0);
    expect_state("r_lag1", 1, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 1'b0);
    tick();
    expect_state("r_count2", 1, 3'b000, 3'b000, 3'b010, 3'b010, 1'b0, 1'b0);
    ri.inc = 1'b1;
    tick();
    expect_state("w_full", 0, 3'b100, 3'b110, 3'b000, 3'b000, 1'b1, 1'b0);
    tick();
    expect_state("w_overflow", 0, 3'b100, 3'b110, 3'b000, 3'b000, 1'b1, 1'b1);
    expect_state("r_drained", 1, 3'b010, 3'b011, 3'b010, 3'b000, 1'b1, 1'b0);
    wi.inc = 1'b0; wi.remote_ptr_gray = 3'b001;
    tick();
    expect_state("w_sync_edge1", 0, 3'b100, 3'b110, 3'b000, 3'b000, 1'b1, 1'b1);
    expect_state("r_underflow", 1, 3'b010, 3'b011, 3'b010, 3'b000, 1'b1, 1'b1);
    ri.inc = 1'b0;
    tick();
    expect_state("w_sync_edge2", 0, 3'b100, 3'b110, 3'b001, 3'b001, 1'b0, 1'b1);

    @(negedge clk);
    #1 run = 1'b0;
    #1 rst_n = 1'b0;
    wi.remote_ptr_gray = 3'b000; ri.remote_ptr_gray = 3'b000;
    #1;
    expect_state("w_async_reset", 0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0);
    expect_state("r_async_reset", 1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    -> chk_ev;
    #3 rst_n = 1'b1;
    #1 run = 1'b1;

    wi.inc = 1'b1; wi.remote_ptr_gray = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expect_state($sformatf("w_wrap%0d", k), 0, 3'(k), gray_tab[k % 8],
                   (k >= 2) ? 3'(k - 2) : 3'b000, (k == 1) ? 3'b011 : 3'b010, 1'b0, 1'b0);
      wi.remote_ptr_gray = gray_tab[k % 8];
    end
    wi.inc = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
